// File: rtl/pe_sched_pkg.sv
// Shared opcode constants, scheduler FSM states and ID-width helper for the
// PE op scheduler and the PE decode.
package pe_sched_pkg;

    localparam logic [3:0] OP_MAC    = 4'h1;
    localparam logic [3:0] OP_MEM    = 4'h4;
    localparam logic [3:0] OP_SPARSE = 4'h8;

    typedef enum logic [1:0] {
        ARB,
        DRAIN,
        MEM_WAIT
    } sched_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_op_scheduler_if.sv
// Requester, PE-issue and completion handshake bundle for pe_op_scheduler.
// master = scheduler side, slave = front-end/PE environment side.
interface pe_op_scheduler_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned INSTR_WIDTH = 32
) ();

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*INSTR_WIDTH-1:0] req_instr;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           pe_valid_o;
    logic [INSTR_WIDTH-1:0]         pe_instr_o;
    logic                           pe_ready_i;
    logic                           pe_done_i;
    logic [NUM_REQ-1:0]             rsp_valid;

    modport master (
        input  req_valid, req_instr, pe_ready_i, pe_done_i,
        output req_ready, pe_valid_o, pe_instr_o, rsp_valid
    );

    modport slave (
        output req_valid, req_instr, pe_ready_i, pe_done_i,
        input  req_ready, pe_valid_o, pe_instr_o, rsp_valid
    );

endinterface

// File: rtl/pe_sched_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every in-flight operation.
module pe_sched_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pe_op_scheduler.sv
// Round-robin scheduler sharing one PE between NUM_REQ requesters, with
// memory-op barriers. Perf counters are built only with PE_SCHED_PERF_EN.
module pe_op_scheduler
    import pe_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned INSTR_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    pe_op_scheduler_if.master                  bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_sticky,
    output logic [CNT_WIDTH-1:0]               perf_issue_cnt,
    output logic [CNT_WIDTH-1:0]               perf_busy_cnt,
    output logic                               perf_overflow
);

    localparam int unsigned IDW = id_width(NUM_REQ);

    sched_state_e           state, state_nxt;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         lock_id, lock_nxt;
    logic [IDW-1:0]         win_id, sel_id;
    logic                   win_found;
    logic [INSTR_WIDTH-1:0] sel_instr;
    logic                   sel_mem;
    logic                   can_accept, grant, accept, pop;
    logic                   fifo_full, fifo_empty;
    logic [IDW-1:0]         fifo_rdata;

    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            automatic int unsigned idx = (32'(ptr) + k) % NUM_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign sel_id     = (state == DRAIN) ? lock_id : win_id;
    assign sel_instr  = bus.req_instr[32'(sel_id)*INSTR_WIDTH +: INSTR_WIDTH];
    assign sel_mem    = (sel_instr[INSTR_WIDTH-1 -: 4] == OP_MEM);
    assign pop        = bus.pe_done_i & ~fifo_empty & ~rst;
    // A done in the same cycle frees the slot a full FIFO would otherwise block.
    assign can_accept = (~bus.pe_valid_o | bus.pe_ready_i) & (~fifo_full | pop);

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_id;
        grant     = 1'b0;
        case (state)
            ARB: begin
                if (win_found) begin
                    if (sel_mem && (outstanding != '0)) begin
                        lock_nxt  = win_id;
                        state_nxt = DRAIN;
                    end else if (can_accept) begin
                        grant = 1'b1;
                        if (sel_mem) begin
                            state_nxt = MEM_WAIT;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!bus.req_valid[lock_id]) begin
                    state_nxt = ARB;
                end else if ((outstanding == '0) && can_accept) begin
                    grant     = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (pop) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign accept = grant & ~rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[sel_id] = 1'b1;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (pop) begin
            bus.rsp_valid[fifo_rdata] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB;
            ptr            <= '0;
            lock_id        <= '0;
            bus.pe_valid_o <= 1'b0;
            bus.pe_instr_o <= '0;
            err_sticky     <= 1'b0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_nxt;
            if (accept) begin
                ptr            <= sel_id;
                bus.pe_valid_o <= 1'b1;
                bus.pe_instr_o <= sel_instr;
            end else if (bus.pe_ready_i) begin
                bus.pe_valid_o <= 1'b0;
            end
            if (bus.pe_done_i && fifo_empty) begin
                err_sticky <= 1'b1;
            end
        end
    end

    pe_sched_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (sel_id),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

`ifdef PE_SCHED_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_NEAR = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_busy_cnt  <= '0;
            perf_overflow  <= 1'b0;
        end else begin
            if (accept && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + CNT_WIDTH'(1);
                if (perf_issue_cnt == CNT_NEAR) begin
                    perf_overflow <= 1'b1;
                end
            end
            if ((outstanding != '0) && (perf_busy_cnt != '1)) begin
                perf_busy_cnt <= perf_busy_cnt + CNT_WIDTH'(1);
                if (perf_busy_cnt == CNT_NEAR) begin
                    perf_overflow <= 1'b1;
                end
            end
        end
    end
`else
    assign perf_issue_cnt = '0;
    assign perf_busy_cnt  = '0;
    assign perf_overflow  = 1'b0;
`endif

endmodule
